// File: rtl/priority_decoder_pipe_if.sv
// Handshake bundle for priority_decoder_pipe.
//   in_valid/in_ready/in        : binary index from the producer
//   out_valid/out_ready/out     : one-hot word of the head entry to the consumer
//   out_err                     : head entry index was out of range (>= m)
//   seen/seen_clr               : sticky mask of popped words and its clear
// slave  : the decoder side
// master : the producer/consumer side driving the decoder
interface priority_decoder_pipe_if #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [m-1:0] out;
    logic         out_err;
    logic [m-1:0] seen;
    logic         seen_clr;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in,
        output out_valid,
        input  out_ready,
        output out,
        output out_err,
        output seen,
        input  seen_clr
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in,
        input  out_valid,
        output out_ready,
        input  out,
        input  out_err,
        input  seen,
        output seen_clr
    );
endinterface

// File: rtl/priority_decoder_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry output buffer.
// An index accepted over the in handshake is decoded at push time and stored;
// the head entry is presented on out/out_err. Out-of-range indices (>= m) are
// stored as an all-zero word with out_err set. seen accumulates every word
// popped downstream until seen_clr.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : priority_decoder_pipe_if.slave (index in, one-hot out, seen mask)
module priority_decoder_pipe #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 3
) (
    input logic                   clk,
    input logic                   rst,
    priority_decoder_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [m-1:0] head_word_q, head_word_d;
    logic         head_err_q, head_err_d;
    logic [m-1:0] tail_word_q, tail_word_d;
    logic         tail_err_q, tail_err_d;
    logic [m-1:0] seen_q, seen_d;

    logic [m-1:0] dec_word;
    logic         dec_err;
    logic         in_ready;
    logic         out_valid;
    logic         push;
    logic         pop;

    // Ready comes from state alone so out_ready never reaches in_ready.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = head_word_q;
    assign bus.out_err   = head_err_q;
    assign bus.seen      = seen_q;

    // Decode; an index >= m yields no line and flags the error instead.
    always_comb begin
        dec_word = '0;
        for (int unsigned i = 0; i < m; i++) begin
            dec_word[i] = (32'(bus.in) == i);
        end
        dec_err = (32'(bus.in) >= m);
    end

    // Head slot is zeroed whenever the buffer drains so out/out_err read 0
    // while out_valid is low without any output gating.
    always_comb begin
        state_d     = state_q;
        head_word_d = head_word_q;
        head_err_d  = head_err_q;
        tail_word_d = tail_word_q;
        tail_err_d  = tail_err_q;

        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d     = StOne;
                    head_word_d = dec_word;
                    head_err_d  = dec_err;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d     = StFull;
                    tail_word_d = dec_word;
                    tail_err_d  = dec_err;
                end else if (push && pop) begin
                    head_word_d = dec_word;
                    head_err_d  = dec_err;
                end else if (pop) begin
                    state_d     = StEmpty;
                    head_word_d = '0;
                    head_err_d  = 1'b0;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d     = StOne;
                    head_word_d = tail_word_q;
                    head_err_d  = tail_err_q;
                    tail_word_d = '0;
                    tail_err_d  = 1'b0;
                end
            end
            default: begin
                state_d     = StEmpty;
                head_word_d = '0;
                head_err_d  = 1'b0;
                tail_word_d = '0;
                tail_err_d  = 1'b0;
            end
        endcase
    end

    // Clear applies before the pop is merged, so a same-cycle pop survives.
    always_comb begin
        seen_d = bus.seen_clr ? '0 : seen_q;
        if (pop) begin
            seen_d = seen_d | head_word_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            head_word_q <= '0;
            head_err_q  <= 1'b0;
            tail_word_q <= '0;
            tail_err_q  <= 1'b0;
            seen_q      <= '0;
        end else begin
            state_q     <= state_d;
            head_word_q <= head_word_d;
            head_err_q  <= head_err_d;
            tail_word_q <= tail_word_d;
            tail_err_q  <= tail_err_d;
            seen_q      <= seen_d;
        end
    end

endmodule

// File: tb/tb_priority_decoder_pipe.sv
// Directed bench for priority_decoder_pipe: an m=8 instance for the main
// behaviour and an m=6 instance for out-of-range indices.
module tb_priority_decoder_pipe;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    priority_decoder_pipe_if #(.m(8), .n(3)) bus8 ();
    priority_decoder_pipe_if #(.m(6), .n(3)) bus6 ();

    priority_decoder_pipe #(.m(8), .n(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    priority_decoder_pipe #(.m(6), .n(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.in = '0; bus8.out_ready = 1'b0; bus8.seen_clr = 1'b0;
        bus6.in_valid = 1'b0; bus6.in = '0; bus6.out_ready = 1'b0; bus6.seen_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_out", 32'(bus8.out), 32'h00);
        check("rst_out_err", 32'(bus8.out_err), 32'd0);
        check("rst_seen", 32'(bus8.seen), 32'h00);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Single transfer
        bus8.in_valid = 1'b1; bus8.in = 3'd3; bus8.out_ready = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        check("single_valid", 32'(bus8.out_valid), 32'd1);
        check("single_out", 32'(bus8.out), 32'h08);
        check("single_err", 32'(bus8.out_err), 32'd0);
        step();
        check("single_seen", 32'(bus8.seen), 32'h08);
        check("single_empty", 32'(bus8.out_valid), 32'd0);
        check("single_out0", 32'(bus8.out), 32'h00);
        check("single_ready", 32'(bus8.in_ready), 32'd1);

        // Backpressure: third push must be refused
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in = 3'd1;
        step();
        check("bp_ready1", 32'(bus8.in_ready), 32'd1);
        bus8.in = 3'd6;
        step();
        check("bp_ready2", 32'(bus8.in_ready), 32'd0);
        bus8.in = 3'd2;
        step();
        bus8.in_valid = 1'b0;
        check("bp_hold", 32'(bus8.out), 32'h02);
        check("bp_full", 32'(bus8.in_ready), 32'd0);
        bus8.out_ready = 1'b1;
        #1;
        check("bp_no_comb_ready", 32'(bus8.in_ready), 32'd0);
        step();
        check("bp_pop1", 32'(bus8.out), 32'h40);
        check("bp_ready3", 32'(bus8.in_ready), 32'd1);
        check("bp_seen1", 32'(bus8.seen), 32'h0A);
        step();
        check("bp_drained", 32'(bus8.out_valid), 32'd0);
        check("bp_seen2", 32'(bus8.seen), 32'h4A);

        // Streaming at one index per cycle
        bus8.seen_clr = 1'b1;
        step();
        bus8.seen_clr = 1'b0;
        check("clr_seen", 32'(bus8.seen), 32'h00);
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.in = 3'(i);
            #1;
            check("stream_ready", 32'(bus8.in_ready), 32'd1);
            step();
            check("stream_valid", 32'(bus8.out_valid), 32'd1);
            check("stream_out", 32'(bus8.out), 32'd1 << i);
        end
        bus8.in_valid = 1'b0;
        step();
        check("stream_seen", 32'(bus8.seen), 32'hFF);

        // Clear racing a pop
        bus8.seen_clr = 1'b1;
        step();
        bus8.seen_clr = 1'b0;
        bus8.in_valid = 1'b1; bus8.in = 3'd0;
        step();
        bus8.in = 3'd2;
        step();
        bus8.in_valid = 1'b0;
        step();
        check("race_seen_pre", 32'(bus8.seen), 32'h05);
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in = 3'd4;
        step();
        bus8.in_valid = 1'b0;
        check("race_head", 32'(bus8.out), 32'h10);
        bus8.seen_clr = 1'b1; bus8.out_ready = 1'b1;
        step();
        bus8.seen_clr = 1'b0;
        check("race_seen", 32'(bus8.seen), 32'h10);
        check("race_empty", 32'(bus8.out_valid), 32'd0);

        // Out-of-range index on m=6
        bus6.out_ready = 1'b1;
        bus6.in_valid = 1'b1; bus6.in = 3'd2;
        step();
        bus6.in_valid = 1'b0;
        check("err_inrange_out", 32'(bus6.out), 32'h04);
        step();
        check("err_seen_pre", 32'(bus6.seen), 32'h04);
        bus6.out_ready = 1'b0;
        bus6.in_valid = 1'b1; bus6.in = 3'd7;
        step();
        bus6.in_valid = 1'b0;
        check("err_valid", 32'(bus6.out_valid), 32'd1);
        check("err_out", 32'(bus6.out), 32'h00);
        check("err_flag", 32'(bus6.out_err), 32'd1);
        bus6.out_ready = 1'b1;
        step();
        check("err_seen_post", 32'(bus6.seen), 32'h04);
        check("err_flag_clr", 32'(bus6.out_err), 32'd0);
        check("err_empty", 32'(bus6.out_valid), 32'd0);

        // Asynchronous reset with the buffer full
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in = 3'd1;
        step();
        bus8.in = 3'd3;
        step();
        bus8.in_valid = 1'b0;
        check("prerst_full", 32'(bus8.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus8.out_valid), 32'd0);
        check("arst_out", 32'(bus8.out), 32'h00);
        check("arst_seen", 32'(bus8.seen), 32'h00);
        check("arst_ready", 32'(bus8.in_ready), 32'd1);
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        check("postrst_valid", 32'(bus8.out_valid), 32'd0);
        check("postrst_seen", 32'(bus8.seen), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
